// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-byte FIFO bus: write strobe, FWFT read side, status
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              clr_overrun;

    modport master (
        output in_data, in_valid, out_ready, clr_overrun,
        input  out_data, out_valid, count, full, empty, overrun
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_overrun,
        output out_data, out_valid, count, full, empty, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular byte FIFO behind the UART receiver with sticky overrun
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overrun_q;

    logic full_w;
    logic empty_w;
    logic pop;
    logic push;
    logic drop;

    // Status comes straight from the registered occupancy, so it only moves on edges or reset.
    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // A pop frees a slot in the same cycle, which lets a push into a full FIFO still land.
    assign pop  = ~empty_w & bus.out_ready;
    assign push = bus.in_valid & (~full_w | pop);
    assign drop = bus.in_valid & full_w & ~pop;

    // Pointers and occupancy; pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    // First-word-fall-through read side; data is forced to zero when nothing is held.
    assign bus.out_valid = ~empty_w;
    assign bus.out_data  = empty_w ? '0 : mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.overrun   = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer directly downstream of the UART receiver. It captures each byte presented with a one-cycle valid pulse and holds it in a circular FIFO. Bytes are offered to the consumer through a first-word-fall-through valid/ready interface. Overruns are reported with a sticky flag, so software or a parser can detect line data lost while the buffer was full.

Parameters:
DATA_W, 8, width of each stored word (UART byte)
DEPTH, 16, number of entries; power of two, minimum 2; ADDR_W = log2(DEPTH) derived internally

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_W  byte from receiver; sampled only when in_valid=1
in_valid  input  1  one-cycle write strobe from receiver (its data_valid)
out_data  output  DATA_W  head-of-FIFO byte; 0 when out_valid=0
out_valid  output  1  FIFO non-empty, out_data meaningful
out_ready  input  1  consumer accepts head when out_valid=1 (pop)
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overrun  output  1  sticky: at least one byte dropped since last clear
clr_overrun  input  1  one-cycle strobe clearing overrun

Behaviour:
- Reset (async assert, sync release on next clk edge): wr_ptr=0, rd_ptr=0, count=0, overrun=0, out_valid=0, out_data=0, empty=1, full=0. Storage contents are don't-care. Reset mid-operation discards all stored bytes immediately.
- Push = in_valid & (~full | pop). Pop = out_valid & out_ready.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH (natural wrap via ADDR_W bits).
- Pop: rd_ptr increments modulo DEPTH; the next entry (or nothing) appears the cycle after.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Latency: a byte pushed into an empty FIFO produces out_valid=1 with that byte on the next clk edge. There is no same-cycle combinational pass-through from in_data to out_data.
- FWFT: out_data = mem[rd_ptr] while out_valid=1, else 0. out_valid = ~empty.
- Full with in_valid=1 and no pop in the same cycle: the byte is dropped and overrun <= 1. Pointers and count are unchanged.
- Full with in_valid=1 and pop in the same cycle: the push is accepted. count stays DEPTH and no overrun is raised.
- Empty with pop requested: impossible, because out_valid=0 gates it. out_ready is ignored while empty.
- Empty with in_valid=1 and out_ready=1: push only. out_valid rises next cycle.
- clr_overrun and an overrun event in the same cycle: set wins, so overrun stays 1.
- out_ready may be held high continuously. This gives one pop per cycle while non-empty.
- full, empty, and count are all registered or derived from the registered count. They change only on clk edges or reset.

Test Plan:
- Reset then idle: assert rst mid-run with 5 bytes stored -> count=0, empty=1, out_valid=0, out_data=0 immediately. After release, no stale byte appears.
- Single byte: pulse in_valid with 0xA5 into empty FIFO, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1. Pulse out_ready -> following cycle out_valid=0, out_data=0, count=0.
- Fill and order: push 0x00..0x0F with out_ready=0 -> full=1, count=16. Drain with out_ready=1 -> bytes read in order 0x00..0x0F, then empty=1.
- Overrun: at full, push 0x55 with no pop -> byte dropped, overrun=1, count=16. Drain shows 0x55 absent. Pulse clr_overrun -> overrun=0.
- Full push+pop: at full, push 0x77 while popping -> count stays 16, overrun=0. 0x77 is read last after the remaining 15 bytes.
- Wrap-around and clear race: run 40 push/pop pairs across pointer wrap -> data intact and in order. Assert clr_overrun in the same cycle as a dropped push -> overrun remains 1.
